// File: rtl/atmega_pcint.sv
// Pin-change interrupt controller for one 8-bit port group.
// AVR-style PCICR/PCIFR/PCMSK registers, synchronised pad inputs, level interrupt request.
module atmega_pcint #(
  parameter int                         BUS_ADDR_IO_LEN = 16,
  parameter logic [BUS_ADDR_IO_LEN-1:0] PCICR_ADDR      = 0,
  parameter logic [BUS_ADDR_IO_LEN-1:0] PCIFR_ADDR      = 1,
  parameter logic [BUS_ADDR_IO_LEN-1:0] PCMSK_ADDR      = 2,
  parameter logic [7:0]                 PINMASK         = 8'hFF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [BUS_ADDR_IO_LEN-1:0] addr,
  input  logic                       wr,
  input  logic                       rd,
  input  logic [7:0]                 bus_in,
  output logic [7:0]                 bus_out,
  input  logic [7:0]                 pin_in,
  output logic                       int_rq,
  input  logic                       int_ack
);

  logic [7:0] s1, s2, prev;
  logic [7:0] pcmsk;
  logic       pcie, pcif;
  logic [1:0] cnt;
  logic       armed, change;
  logic       wr_pcicr, wr_pcifr, wr_pcmsk;

  assign wr_pcicr = wr && (addr == PCICR_ADDR);
  assign wr_pcifr = wr && (addr == PCIFR_ADDR);
  assign wr_pcmsk = wr && (addr == PCMSK_ADDR);

  // Detection is held off until the synchroniser and prev have filled after reset.
  assign armed  = (cnt == 2'd3);
  assign change = (|((s2 ^ prev) & pcmsk & PINMASK)) & armed;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1   <= 8'h00;
      s2   <= 8'h00;
      prev <= 8'h00;
      cnt  <= 2'd0;
    end else begin
      s1   <= pin_in;
      s2   <= s1;
      prev <= s2;
      if (cnt != 2'd3) cnt <= cnt + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pcie  <= 1'b0;
      pcmsk <= 8'h00;
    end else begin
      if (wr_pcicr) pcie  <= bus_in[0];
      if (wr_pcmsk) pcmsk <= bus_in & PINMASK;
    end
  end

  // A new change always wins over a clear arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst)                       pcif <= 1'b0;
    else if (change)                pcif <= 1'b1;
    else if (wr_pcifr && bus_in[0]) pcif <= 1'b0;
    else if (int_ack)               pcif <= 1'b0;
  end

  assign int_rq = pcie & pcif;

  always_comb begin
    bus_out = 8'h00;
    if (rd) begin
      if (addr == PCICR_ADDR)      bus_out = {7'b0, pcie};
      else if (addr == PCIFR_ADDR) bus_out = {7'b0, pcif};
      else if (addr == PCMSK_ADDR) bus_out = pcmsk;
    end
  end

endmodule

// File: tb/tb_atmega_pcint.sv
// Directed bench for atmega_pcint: arming, trigger, masking, clear priority, enable, reset.
// A second instance with only the low nibble present checks PINMASK behaviour.
module tb_atmega_pcint;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] addr = 16'd0;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic [7:0]  bus_in = 8'h00;
  logic [7:0]  pin_in = 8'h00;
  logic        int_ack = 1'b0;
  logic [7:0]  bus_out_a, bus_out_b;
  logic        int_rq_a, int_rq_b;

  int n_cmp = 0;
  int n_err = 0;

  atmega_pcint dut_a (
    .clk(clk), .rst(rst), .addr(addr), .wr(wr), .rd(rd), .bus_in(bus_in),
    .bus_out(bus_out_a), .pin_in(pin_in), .int_rq(int_rq_a), .int_ack(int_ack)
  );

  atmega_pcint #(.PINMASK(8'h0F)) dut_b (
    .clk(clk), .rst(rst), .addr(addr), .wr(wr), .rd(rd), .bus_in(bus_in),
    .bus_out(bus_out_b), .pin_in(pin_in), .int_rq(int_rq_b), .int_ack(int_ack)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic write_reg(input logic [15:0] a, input logic [7:0] d);
    addr = a; bus_in = d; wr = 1'b1;
    tick();
    wr = 1'b0; bus_in = 8'h00;
  endtask

  task automatic read_a(input logic [15:0] a, input logic [7:0] exp, input string tag);
    addr = a; rd = 1'b1;
    #1;
    check(tag, bus_out_a, exp);
    rd = 1'b0;
    #1;
  endtask

  task automatic read_b(input logic [15:0] a, input logic [7:0] exp, input string tag);
    addr = a; rd = 1'b1;
    #1;
    check(tag, bus_out_b, exp);
    rd = 1'b0;
    #1;
  endtask

  initial begin
    // reset with all pins high
    rst = 1'b0; pin_in = 8'hFF;
    tick(3);
    check("rst_int_rq", {7'b0, int_rq_a}, 8'h00);
    check("rst_bus_idle", bus_out_a, 8'h00);
    read_a(16'd0, 8'h00, "rst_pcicr");
    read_a(16'd2, 8'h00, "rst_pcmsk");

    // arming: mask fully open on the very first cycle, pins stay high
    rst = 1'b1;
    write_reg(16'd2, 8'hFF);
    tick(10);
    read_a(16'd1, 8'h00, "arm_pcif");
    check("arm_int_rq", {7'b0, int_rq_a}, 8'h00);
    read_a(16'd2, 8'hFF, "pcmsk_rb_a");
    read_b(16'd2, 8'h0F, "pcmsk_rb_b");

    // quiet pins to 0 with mask closed
    write_reg(16'd2, 8'h00);
    pin_in = 8'h00;
    tick(4);
    read_a(16'd1, 8'h00, "quiet_pcif");

    // basic trigger on pin 2
    write_reg(16'd2, 8'h04);
    write_reg(16'd0, 8'h01);
    pin_in = 8'h04;
    tick();
    read_a(16'd1, 8'h00, "lat_e0");
    tick();
    read_a(16'd1, 8'h00, "lat_e1");
    check("lat_e1_rq", {7'b0, int_rq_a}, 8'h00);
    tick();
    read_a(16'd1, 8'h01, "lat_e2");
    check("lat_e2_rq", {7'b0, int_rq_a}, 8'h01);

    // write-one-to-clear
    write_reg(16'd1, 8'h00);
    read_a(16'd1, 8'h01, "w0_noclr");
    write_reg(16'd1, 8'h01);
    read_a(16'd1, 8'h00, "w1_clr");
    check("w1_clr_rq", {7'b0, int_rq_a}, 8'h00);

    // masked pin 5 toggles
    pin_in = 8'h24;
    tick(4);
    read_a(16'd1, 8'h00, "mask_pin5");

    // trigger again, clear by ack
    pin_in = 8'h20;
    tick(3);
    read_a(16'd1, 8'h01, "retrig");
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    read_a(16'd1, 8'h00, "ack_clr");
    check("ack_clr_rq", {7'b0, int_rq_a}, 8'h00);

    // set wins over ack in the same cycle
    pin_in = 8'h24;
    tick(2);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    read_a(16'd1, 8'h01, "set_vs_ack");
    write_reg(16'd1, 8'h01);
    read_a(16'd1, 8'h00, "clr_after_ack");

    // set wins over write-one-to-clear in the same cycle
    pin_in = 8'h20;
    tick(2);
    write_reg(16'd1, 8'h01);
    read_a(16'd1, 8'h01, "set_vs_wr");
    write_reg(16'd1, 8'h01);

    // pending flag with interrupt disabled, then enable
    write_reg(16'd0, 8'h00);
    pin_in = 8'h24;
    tick(3);
    read_a(16'd1, 8'h01, "pend_pcif");
    check("pend_rq_off", {7'b0, int_rq_a}, 8'h00);
    write_reg(16'd0, 8'h01);
    check("pend_rq_on", {7'b0, int_rq_a}, 8'h01);
    read_a(16'd0, 8'h01, "pcicr_rb");

    // absent pin 7 never triggers on the nibble-wide instance
    write_reg(16'd1, 8'h01);
    write_reg(16'd2, 8'hFF);
    pin_in = 8'hA4;
    tick(3);
    read_a(16'd1, 8'h01, "pin7_a");
    read_b(16'd1, 8'h00, "pin7_b");
    check("pin7_b_rq", {7'b0, int_rq_b}, 8'h00);

    // reset mid-operation drops pending flag and re-arms
    rst = 1'b0;
    tick();
    check("mid_rst_rq", {7'b0, int_rq_a}, 8'h00);
    read_a(16'd1, 8'h00, "mid_rst_pcif");
    rst = 1'b1;
    write_reg(16'd2, 8'hFF);
    write_reg(16'd0, 8'h01);
    tick(6);
    read_a(16'd1, 8'h00, "rearm_pcif");
    check("rearm_rq", {7'b0, int_rq_a}, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
